// File: rtl/serial_add_sub_pkg.sv
// Shared types for the digit-serial adder/subtractor: FSM state encoding and
// the digit counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// Single-bit full-adder cell; the top chains DIGIT of these per clock.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_add_sub
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_add_sub: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  // Handshake: start is accepted on any edge where the block is not in RUN;
  // done is a one-cycle pulse and sum/cout/ovf hold until the next acceptance.
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, acc_sr, acc_nx, dig_ext, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dig_s;
  logic             last, accept;

  assign c[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fa_cell u_fa (
      .a  (a_sr[i]),
      .b  (b_sr[i]),
      .ci (c[i]),
      .s  (dig_s[i]),
      .co (c[i+1])
    );
  end

  assign last   = (cnt == CW'(N - 1));
  assign accept = start && (state != RUN);

  // New digit enters at the MSB so the result is LSB-aligned after N shifts.
  always_comb begin
    dig_ext = WIDTH'(dig_s);
    acc_nx  = (acc_sr >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b ^ {WIDTH{sub}};
      carry <= cin ^ sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      acc_sr <= acc_nx;
      carry  <= c[DIGIT];
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum_q  <= acc_nx;
        cout_q <= c[DIGIT];
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q;

  // Carry into vs. out of the MSB cell of the final digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ovf_q <= 1'b0;
    else if (!accept && state == RUN && last) ovf_q <= c[DIGIT] ^ c[DIGIT-1];
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three instances (DIGIT = 1, 4, 8 at WIDTH = 8)
// checked against an arithmetic reference model.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_v[3];
  logic         sub_v[3];
  logic         cin_v[3];
  logic [W-1:0] a_v[3];
  logic [W-1:0] b_v[3];
  logic         busy_v[3];
  logic         done_v[3];
  logic         cout_v[3];
  logic         ovf_v[3];
  logic [W-1:0] sum_v[3];

  logic [W+1:0] exp_q[$];
  logic [W-1:0] prev_sum[3];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a_v[0]), .b(b_v[0]),
    .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]),
    .ovf(ovf_v[0]));

  serial_add_sub #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a_v[1]), .b(b_v[1]),
    .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]),
    .ovf(ovf_v[1]));

  serial_add_sub #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .a(a_v[2]), .b(b_v[2]),
    .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]),
    .ovf(ovf_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int num_digits(input int d);
    return (d == 0) ? 8 : (d == 1) ? 2 : 1;
  endfunction

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin);
    logic [W-1:0] bb;
    int           u, s;
    logic         o;
    bb = sub ? (8'hFF - b) : b;
    u  = int'(a) + int'(bb) + int'(cin ^ sub);
    s  = int'($signed(a)) + int'($signed(bb)) + int'(cin ^ sub);
`ifdef SERIAL_ADDSUB_OVF_EN
    o = (s > 127) || (s < -128);
`else
    o = 1'b0;
`endif
    return {o, u[8], u[7:0]};
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input bit glitch);
    int           n;
    int           k;
    logic [W+1:0] e;
    n = num_digits(d);
    exp_q.push_back(model(a, b, sub, cin));
    start_v[d] = 1'b1;
    a_v[d] = a;
    b_v[d] = b;
    sub_v[d] = sub;
    cin_v[d] = cin;
    @(negedge clk);
    start_v[d] = 1'b0;
    a_v[d] = W'($urandom);
    b_v[d] = W'($urandom);
    sub_v[d] = 1'($urandom);
    cin_v[d] = 1'($urandom);
    k = 1;
    check("busy_after_start", 32'(busy_v[d]), 32'd1);
    check("sum_shadow", 32'(sum_v[d]), 32'(prev_sum[d]));
    while (!done_v[d] && k <= n + 4) begin
      start_v[d] = (glitch && k == 3);
      @(negedge clk);
      k++;
    end
    start_v[d] = 1'b0;
    e = exp_q.pop_front();
    check("latency", 32'(k), 32'(n + 1));
    check("busy_at_done", 32'(busy_v[d]), 32'd0);
    check("sum", 32'(sum_v[d]), 32'(e[7:0]));
    check("cout", 32'(cout_v[d]), 32'(e[8]));
    check("ovf", 32'(ovf_v[d]), 32'(e[9]));
    prev_sum[d] = e[7:0];
  endtask

  task automatic idle_check(input int d);
    @(negedge clk);
    check("done_pulse_width", 32'(done_v[d]), 32'd0);
    check("sum_hold", 32'(sum_v[d]), 32'(prev_sum[d]));
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; sub_v[i] = 1'b0; cin_v[i] = 1'b0;
      a_v[i] = '0; b_v[i] = '0; prev_sum[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", 32'(busy_v[i]), 32'd0);
      check("rst_done", 32'(done_v[i]), 32'd0);
      check("rst_sum", 32'(sum_v[i]), 32'd0);
      check("rst_cout", 32'(cout_v[i]), 32'd0);
      check("rst_ovf", 32'(ovf_v[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed add / subtract cases on the bit-serial instance.
    run_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0); idle_check(0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0); idle_check(0);
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0); idle_check(0);
    run_op(0, 8'h10, 8'h01, 1'b1, 1'b0, 1'b0); idle_check(0);
    run_op(0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0); idle_check(0);
    run_op(0, 8'h05, 8'h02, 1'b1, 1'b1, 1'b0); idle_check(0);
    run_op(0, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0); idle_check(0);

    // Back-to-back from DONE, second op with a start pulse mid-RUN.
    run_op(0, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
    run_op(0, 8'hA0, 8'h30, 1'b1, 1'b0, 1'b1);
    idle_check(0);

    // Reset three cycles into RUN: everything clears, no done follows.
    start_v[0] = 1'b1; a_v[0] = 8'hC3; b_v[0] = 8'h5C; sub_v[0] = 1'b0; cin_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_rst", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(busy_v[0]), 32'd0);
    check("midrun_rst_done", 32'(done_v[0]), 32'd0);
    check("midrun_rst_sum", 32'(sum_v[0]), 32'd0);
    check("midrun_rst_cout", 32'(cout_v[0]), 32'd0);
    for (int i = 0; i < 3; i++) prev_sum[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done_v[0]), 32'd0);
    end
    run_op(0, 8'hC3, 8'h5C, 1'b0, 1'b1, 1'b0); idle_check(0);

    // Randomized traffic on every instance, sometimes back-to-back.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 20; i++) begin
        run_op(d, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        if ($urandom_range(0, 1) == 1) idle_check(d);
      end
      idle_check(d);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
